step_ramp_gen: RTL



---
 rtl/step_ramp_gen_pkg.sv | 14 +
 rtl/step_ramp_gen.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/step_ramp_gen_pkg.sv
// Shared constants for the step ramp generator: FSM state codes
// and default counter widths.
package step_ramp_gen_pkg;

    localparam int DIV_W_DEF = 16;
    localparam int CNT_W_DEF = 16;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ACCEL  = 3'd1;
    localparam logic [2:0] S_CRUISE = 3'd2;
    localparam logic [2:0] S_DECEL  = 3'd3;
    localparam logic [2:0] S_FIN    = 3'd4;

endpackage

// File: rtl/step_ramp_gen.sv
// Trapezoidal STEP pulse generator feeding the phase sequencer.
// Optional STOP abort input when STEP_RAMP_ABORT_EN is defined.
module step_ramp_gen
    import step_ramp_gen_pkg::*;
#(
    parameter int DIV_W     = DIV_W_DEF,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int START_DIV = 1000,
    parameter int MIN_DIV   = 250,
    parameter int ACCEL_DEC = 50
) (
    input  logic             C_IN,
    input  logic             CLR,
    input  logic             START,
    input  logic [CNT_W-1:0] STEPS,
    input  logic             DIR,
`ifdef STEP_RAMP_ABORT_EN
    input  logic             STOP,
`endif
    output logic             STEP,
    output logic             DIR_OUT,
    output logic             BUSY,
    output logic             DONE
);

    localparam logic [DIV_W-1:0] DIV_START = DIV_W'(START_DIV);
    localparam logic [DIV_W-1:0] DIV_MIN   = DIV_W'(MIN_DIV);
    localparam logic [DIV_W-1:0] DIV_STEP  = DIV_W'(ACCEL_DEC);
    localparam logic [DIV_W-1:0] DIV_LIM   = DIV_W'(MIN_DIV + ACCEL_DEC);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] ramp_q, ramp_d;
    logic [DIV_W-1:0] cur_div_q, cur_div_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             step_q, step_d;
    logic             dir_q, dir_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             tick;
    logic [CNT_W-1:0] rem_dec;
    logic [DIV_W:0]   div_sum;
    logic [DIV_W-1:0] div_up;

    assign tick    = (cnt_q == cur_div_q - DIV_W'(1));
    assign rem_dec = rem_q - CNT_W'(1);
    assign div_sum = {1'b0, cur_div_q} + {1'b0, DIV_STEP};
    // Deceleration saturates at the slowest rate.
    assign div_up  = (div_sum > {1'b0, DIV_START}) ? DIV_START
                                                   : div_sum[DIV_W-1:0];

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        ramp_d    = ramp_q;
        cur_div_d = cur_div_q;
        cnt_d     = cnt_q;
        step_d    = 1'b0;
        dir_d     = dir_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    rem_d     = STEPS;
                    dir_d     = DIR;
                    cur_div_d = DIV_START;
                    ramp_d    = '0;
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    state_d   = (STEPS == '0) ? S_FIN : S_ACCEL;
                end
            end
            S_ACCEL, S_CRUISE, S_DECEL: begin
                cnt_d = cnt_q + DIV_W'(1);
                if (tick) begin
                    cnt_d  = '0;
                    step_d = 1'b1;
                    rem_d  = rem_dec;
                    if (rem_dec == '0) begin
                        state_d = S_FIN;
                    end else if (rem_dec <= ramp_q) begin
                        state_d   = S_DECEL;
                        cur_div_d = div_up;
                    end else if (state_q == S_ACCEL) begin
                        ramp_d = ramp_q + CNT_W'(1);
                        if (cur_div_q <= DIV_LIM) begin
                            cur_div_d = DIV_MIN;
                            state_d   = S_CRUISE;
                        end else begin
                            cur_div_d = cur_div_q - DIV_STEP;
                        end
                    end
                end
`ifdef STEP_RAMP_ABORT_EN
                // Abort leaves just enough steps to ramp back down.
                if (STOP && state_q != S_DECEL
                    && rem_d > ramp_q + CNT_W'(1)) begin
                    rem_d = ramp_q + CNT_W'(1);
                end
`endif
            end
            S_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge C_IN or posedge CLR) begin
        if (CLR) begin
            state_q   <= S_IDLE;
            rem_q     <= '0;
            ramp_q    <= '0;
            cur_div_q <= '0;
            cnt_q     <= '0;
            step_q    <= 1'b0;
            dir_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            ramp_q    <= ramp_d;
            cur_div_q <= cur_div_d;
            cnt_q     <= cnt_d;
            step_q    <= step_d;
            dir_q     <= dir_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign STEP    = step_q;
    assign DIR_OUT = dir_q;
    assign BUSY    = busy_q;
    assign DONE    = done_q;

endmodule
